systolic_feeder: RTL and testbench

Input staging and skew stage for the 3x3 systolic multiplier array. It accepts two 3x3 operand matrices A and B over a three-beat valid/ready load interface and buffers them internally. It then drives the array's A0..A2 / B0..B2 edge inputs with the diagonally skewed wavefront, holding the array's `start` high for exactly the array's 8-cycle count window. It blocks new loads until the array reports `Done`.

---
 rtl/systolic_feeder.sv | 173 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Input staging and skew stage for a 3x3 systolic multiplier
//               array. Captures operand matrices A and B over a three-beat
//               valid/ready load, then drives the array's row/column edges
//               with a diagonally skewed, zero-padded wavefront. The array's
//               start is held high for its 8-cycle count window, and new
//               loads are blocked until the array reports Done.
// Ports       : CLK, RSTn            clock, async active-low reset
//               in_valid/in_ready    load beat handshake
//               in_a_row, in_b_row   row k of A / B, element c at [c*W +: W]
//               array_done           array Done flag
//               A0..A2, B0..B2       registered edge operands to the array
//               start                registered array start
//               busy                 high outside LOAD
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int DATAWIDTN = 8
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3*DATAWIDTN-1:0] in_a_row,
  input  logic [3*DATAWIDTN-1:0] in_b_row,
  input  logic                   array_done,
  output logic [DATAWIDTN-1:0]   A0,
  output logic [DATAWIDTN-1:0]   A1,
  output logic [DATAWIDTN-1:0]   A2,
  output logic [DATAWIDTN-1:0]   B0,
  output logic [DATAWIDTN-1:0]   B1,
  output logic [DATAWIDTN-1:0]   B2,
  output logic                   start,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_LOAD      = 2'd0,
    S_FEED      = 2'd1,
    S_DRAIN     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [1:0] C_LAST_BEAT = 2'd2;
  localparam logic [2:0] C_LAST_FEED = 3'd4;
  localparam logic [2:0] C_LAST_T    = 3'd7;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_beat, w_beat_nxt;
  logic [2:0]           r_t, w_t_nxt;
  logic                 r_start, w_start_nxt;
  logic [DATAWIDTN-1:0] r_op_a [3];
  logic [DATAWIDTN-1:0] r_op_b [3];
  logic [DATAWIDTN-1:0] w_op_a_nxt [3];
  logic [DATAWIDTN-1:0] w_op_b_nxt [3];
  logic                 w_xfer;

  // Operand buffer: no reset, contents survive until the next load.
  logic [DATAWIDTN-1:0] r_buf_a [3][3];
  logic [DATAWIDTN-1:0] r_buf_b [3][3];

  assign in_ready = (r_state == S_LOAD) && (r_beat < 2'd3);
  assign busy     = (r_state != S_LOAD);
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (w_xfer) begin
      for (int c = 0; c < 3; c++) begin
        r_buf_a[r_beat][c] <= in_a_row[c*DATAWIDTN +: DATAWIDTN];
        r_buf_b[r_beat][c] <= in_b_row[c*DATAWIDTN +: DATAWIDTN];
      end
    end
  end

  // Next-state and next-output decode. The registered t selects which
  // anti-diagonal of the buffers reaches the array edges on the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_t_nxt     = r_t;
    w_start_nxt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_op_a_nxt[i] = '0;
      w_op_b_nxt[i] = '0;
    end

    case (r_state)
      S_LOAD: begin
        if (w_xfer) begin
          w_beat_nxt = r_beat + 2'd1;
          if (r_beat == C_LAST_BEAT) begin
            w_state_nxt = S_FEED;
            w_t_nxt     = 3'd0;
          end
        end
      end

      S_FEED: begin
        w_start_nxt = 1'b1;
        // A_i = A[i][t-i] and B_j = B[t-j][j] where the index is in range;
        // every other slot stays zero so accumulators see clean padding.
        for (int i = 0; i < 3; i++) begin
          for (int c = 0; c < 3; c++) begin
            if (r_t == 3'(i + c)) begin
              w_op_a_nxt[i] = r_buf_a[i][c];
              w_op_b_nxt[i] = r_buf_b[c][i];
            end
          end
        end
        w_t_nxt = r_t + 3'd1;
        if (r_t == C_LAST_FEED) begin
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        w_start_nxt = 1'b1;
        w_t_nxt     = r_t + 3'd1;
        if (r_t == C_LAST_T) begin
          w_state_nxt = S_WAIT_DONE;
          w_t_nxt     = 3'd0;
        end
      end

      S_WAIT_DONE: begin
        if (array_done) begin
          w_state_nxt = S_LOAD;
          w_beat_nxt  = 2'd0;
        end
      end

      default: begin
        w_state_nxt = S_LOAD;
        w_beat_nxt  = 2'd0;
        w_t_nxt     = 3'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_LOAD;
      r_beat  <= 2'd0;
      r_t     <= 3'd0;
      r_start <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_op_a[i] <= '0;
        r_op_b[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_t     <= w_t_nxt;
      r_start <= w_start_nxt;
      for (int i = 0; i < 3; i++) begin
        r_op_a[i] <= w_op_a_nxt[i];
        r_op_b[i] <= w_op_b_nxt[i];
      end
    end
  end

  assign A0    = r_op_a[0];
  assign A1    = r_op_a[1];
  assign A2    = r_op_a[2];
  assign B0    = r_op_b[0];
  assign B1    = r_op_b[1];
  assign B2    = r_op_b[2];
  assign start = r_start;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_feeder
// Description : Self-checking bench for systolic_feeder. Each load's expected
//               edge waveform is computed from the skew formulas applied to
//               the loaded matrices; the array's Done is emulated here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RSTn = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [3*W-1:0] in_a_row = '0;
  logic [3*W-1:0] in_b_row = '0;
  logic           array_done = 1'b0;
  logic [W-1:0]   A0, A1, A2, B0, B1, B2;
  logic           start;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;

  int ma [3][3];
  int mb [3][3];

  systolic_feeder #(.DATAWIDTN(W)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a_row   (in_a_row),
    .in_b_row   (in_b_row),
    .array_done (array_done),
    .A0         (A0),
    .A1         (A1),
    .A2         (A2),
    .B0         (B0),
    .B1         (B1),
    .B2         (B2),
    .start      (start),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int get_a(input int i);
    case (i)
      0:       return int'(A0);
      1:       return int'(A1);
      default: return int'(A2);
    endcase
  endfunction

  function automatic int get_b(input int j);
    case (j)
      0:       return int'(B0);
      1:       return int'(B1);
      default: return int'(B2);
    endcase
  endfunction

  // Reference skew: wavefront position t, edge index i.
  function automatic int exp_a(input int t, input int i);
    int c;
    c = t - i;
    if (t <= 4 && c >= 0 && c <= 2) return ma[i][c] % 256;
    return 0;
  endfunction

  function automatic int exp_b(input int t, input int j);
    int k;
    k = t - j;
    if (t <= 4 && k >= 0 && k <= 2) return mb[k][j] % 256;
    return 0;
  endfunction

  task automatic check_idle_ops(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_A"}, get_a(i), 0);
      chk({tag, "_B"}, get_b(i), 0);
    end
    chk({tag, "_start"}, int'(start), 0);
  endtask

  // Called away from a clock edge; returns #1 after the edge that took beat 2.
  task automatic load(input int max_gap);
    for (int k = 0; k < 3; k++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge CLK); #1;
      end
      for (int c = 0; c < 3; c++) begin
        in_a_row[c*W +: W] = W'(ma[k][c]);
        in_b_row[c*W +: W] = W'(mb[k][c]);
      end
      in_valid = 1'b1;
      chk("ready_in_load", int'(in_ready), 1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      in_a_row = '0;
      in_b_row = '0;
    end
    chk("ready_after_beat2", int'(in_ready), 0);
    chk("busy_after_beat2", int'(busy), 1);
  endtask

  // Checks the 8-cycle window after load, a stray load pulse and a stray
  // Done pulse during the window, then Done gating in WAIT_DONE.
  task automatic feed_check(input int hold_cycles);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t%0d_A%0d", cyc - 1, i), get_a(i), exp_a(cyc - 1, i));
        chk($sformatf("t%0d_B%0d", cyc - 1, i), get_b(i), exp_b(cyc - 1, i));
      end
      chk($sformatf("t%0d_start", cyc - 1), int'(start), 1);
      chk("busy_window", int'(busy), 1);
      chk("ready_window", int'(in_ready), 0);
      in_valid   = (cyc == 3);
      in_a_row   = (cyc == 3) ? '1 : '0;
      in_b_row   = (cyc == 3) ? '1 : '0;
      array_done = (cyc == 5);
    end
    in_valid   = 1'b0;
    array_done = 1'b0;
    for (int w = 0; w <= hold_cycles; w++) begin
      @(posedge CLK); #1;
      check_idle_ops("wait");
      chk("wait_busy", int'(busy), 1);
      chk("wait_ready", int'(in_ready), 0);
    end
    array_done = 1'b1;
    @(posedge CLK); #1;
    array_done = 1'b0;
    chk("done_busy", int'(busy), 0);
    chk("done_ready", int'(in_ready), 1);
    check_idle_ops("done");
  endtask

  task automatic run(input int max_gap, input int hold_cycles);
    load(max_gap);
    feed_check(hold_cycles);
  endtask

  initial begin
    // Reset state while RSTn is held low.
    #12;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    check_idle_ops("rst");
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_ready", int'(in_ready), 1);

    // Identity x sequence.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 3 * r + c + 1;
      end
    run(0, 0);

    // Skew pattern with gapped handshake.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 10 * r + c + 1;
        mb[r][c] = 10 * r + c + 1;
      end
    run(2, 0);

    // Done gating: array_done held low for 20 cycles past the window.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = int'($urandom_range(255, 0));
        mb[r][c] = int'($urandom_range(255, 0));
      end
    run(1, 20);

    // Randomised loads.
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          ma[r][c] = int'($urandom_range(255, 0));
          mb[r][c] = int'($urandom_range(255, 0));
        end
      run(3, int'($urandom_range(4, 0)));
    end

    // Mid-feed reset at t = 2.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 20 + 3 * r + c;
        mb[r][c] = 40 + 3 * r + c;
      end
    load(0);
    repeat (3) @(posedge CLK);
    #1;
    chk("pre_rst_A0", int'(A0), exp_a(2, 0));
    chk("pre_rst_B2", int'(B2), exp_b(2, 2));
    #2;
    RSTn = 1'b0;
    #1;
    check_idle_ops("midrst");
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(in_ready), 1);
    @(negedge CLK);
    RSTn = 1'b1;

    // Partial load discarded by a second reset.
    for (int c = 0; c < 3; c++) begin
      in_a_row[c*W +: W] = 8'hAA;
      in_b_row[c*W +: W] = 8'h55;
    end
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("partial_busy", int'(busy), 0);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;

    // Full load of maximum values after reset.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = 255;
        mb[r][c] = 255;
      end
    run(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the bench normally ends far earlier.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
